alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0, meaning 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  request present.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 SHALL have ports req0_op / req1_op  input  2  00 add, 01 sub, 10 and, 11 or.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-011 SHALL have port rsp_result  output  32  ALU result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 In IDLE, if any reqX_valid is high, the block SHALL grant one requester, assert only its reqX_ready combinationally in that cycle, capture a/b/op/id at the clock edge, and move to EXEC.
REQ-015 reqX_ready SHALL be high only in IDLE, only for the granted requester; the handshake is reqX_valid && reqX_ready.
REQ-016 Grant with PRIO_FIXED=0 SHALL prefer the requester indicated by rr_ptr; rr_ptr SHALL toggle to the other requester after each completed response.
REQ-017 Grant with PRIO_FIXED=1 SHALL select requester 0 whenever req0_valid is high.
REQ-018 EXEC SHALL last exactly one cycle, register the ALU output into rsp_result, and move to RESP.
REQ-019 In RESP, rsp_valid SHALL be high and rsp_result/rsp_id SHALL be stable until rsp_valid && rsp_ready, after which the FSM SHALL return to IDLE.
REQ-020 Latency from request accept edge to rsp_valid high SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-021 Add/sub SHALL be modulo 2^32 (carry discarded); and/or SHALL be bitwise.
REQ-022 Requester payload changes while not accepted SHALL have no effect; only the captured values are used.

Reset
REQ-023 Reset SHALL force state IDLE, rsp_valid 0, rsp_result 0, rsp_id 0, rr_ptr 0, captured operands 0, busy 0, regardless of clk.
REQ-024 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response ever issued.

Configuration
REQ-025 With macro ALU_ARB_OVF_EN defined, the block SHALL add output rsp_ovf (1 bit): signed two's-complement overflow for add/sub, 0 for and/or, registered alongside rsp_result, reset to 0.
REQ-026 Without ALU_ARB_OVF_EN, port rsp_ovf and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-027 A shared package alu_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_AND, OP_OR) and the FSM state typedef.
REQ-028 The combinational ALU SHALL be a sub-module alu_core (a, b, op -> result, ovf), instantiated once inside alu_arbiter.

Verification
REQ-029 After reset, req0 add 5+7 -> req0_ready high for 1 cycle, rsp_valid 2 cycles later, rsp_result 12, rsp_id 0.
REQ-030 Both valid with rr_ptr 0: req0 sub 10-3, req1 and 0xF0F0&0xFF00 -> first response 7/id 0, second response 0x0000F000/id 1.
REQ-031 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_result, rsp_id stable; both readys 0; busy 1.
REQ-032 Add 0xFFFFFFFF+1 -> result 0, rsp_ovf 0; add 0x7FFFFFFF+1 -> 0x80000000, rsp_ovf 1 (with ALU_ARB_OVF_EN).
REQ-033 Reset pulse during EXEC -> rsp_valid 0 immediately, FSM IDLE, no response for the aborted operation.
REQ-034 PRIO_FIXED=1 with both valid continuously for 10 operations -> every rsp_id 0, req1_ready never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: operand width, op encodings
// and FSM state constants.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: modulo-2^DATA_W add/sub, bitwise and/or, plus signed
// two's-complement overflow flag for add/sub (0 for logic ops).
module alu_core
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              ovf
);

   logic signed [DATA_W-1:0] sa;
   logic signed [DATA_W-1:0] sb;
   logic signed [DATA_W-1:0] sum;
   logic signed [DATA_W-1:0] diff;

   function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                    input logic signed [DATA_W-1:0] y,
                                    input logic signed [DATA_W-1:0] s);
      return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
   endfunction

   // Subtraction overflows only when the operand signs differ.
   function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                    input logic signed [DATA_W-1:0] y,
                                    input logic signed [DATA_W-1:0] d);
      return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
   endfunction

   assign sa   = a;
   assign sb   = b;
   assign sum  = sa + sb;
   assign diff = sa - sb;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum;
            ovf    = add_ovf(sa, sb, sum);
         end
         OP_SUB: begin
            result = diff;
            ovf    = sub_ovf(sa, sb, diff);
         end
         OP_AND:  result = a & b;
         default: result = a | b;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: IDLE grants one request, EXEC computes, RESP holds the
// result until consumed. Optional rsp_ovf output enabled by macro ALU_ARB_OVF_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int PRIO_FIXED = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [1:0]        req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [1:0]        req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
`ifdef ALU_ARB_OVF_EN
   output logic              rsp_ovf,
`endif
   output logic              busy
);

   state_t                   state;
   logic                     rr_ptr;
   logic                     idle;
   logic                     sel1;
   logic                     accept;

   logic signed [DATA_W-1:0] a_p0;
   logic signed [DATA_W-1:0] b_p0;
   logic [1:0]               op_p0;
   logic                     id_p0;

   logic [DATA_W-1:0]        alu_result;
`ifdef ALU_ARB_OVF_EN
   logic                     alu_ovf;
`else
   logic                     alu_ovf_unused;
`endif

   assign idle = (state == ST_IDLE);

   // sel1 chooses requester 1; only meaningful when that requester is valid.
   always_comb begin
      sel1 = 1'b0;
      if (PRIO_FIXED != 0)
         sel1 = req1_valid && !req0_valid;
      else
         sel1 = req1_valid && (!req0_valid || rr_ptr);
   end

   assign req0_ready = idle && req0_valid && !sel1;
   assign req1_ready = idle && req1_valid && sel1;
   assign accept     = req0_ready || req1_ready;

   assign rsp_valid  = (state == ST_RESP);
   assign rsp_id     = id_p0;
   assign busy       = !idle;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         rr_ptr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) state <= ST_EXEC;
            ST_EXEC: state <= ST_RESP;
            ST_RESP: begin
               if (rsp_ready) begin
                  rr_ptr <= !rr_ptr;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Stage p0: capture the granted request's payload at the accept edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_p0  <= '0;
         b_p0  <= '0;
         op_p0 <= OP_ADD;
         id_p0 <= 1'b0;
      end else if (accept) begin
         a_p0  <= sel1 ? req1_a  : req0_a;
         b_p0  <= sel1 ? req1_b  : req0_b;
         op_p0 <= sel1 ? req1_op : req0_op;
         id_p0 <= sel1;
      end
   end

   alu_core u_alu_core (
      .a      (a_p0),
      .b      (b_p0),
      .op     (op_p0),
      .result (alu_result),
`ifdef ALU_ARB_OVF_EN
      .ovf    (alu_ovf)
`else
      .ovf    (alu_ovf_unused)
`endif
   );

   // Stage p1: register the ALU output during EXEC; held through RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_result <= '0;
`ifdef ALU_ARB_OVF_EN
         rsp_ovf    <= 1'b0;
`endif
      end else if (state == ST_EXEC) begin
         rsp_result <= alu_result;
`ifdef ALU_ARB_OVF_EN
         rsp_ovf    <= alu_ovf;
`endif
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, rsp_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]  req0_op, req1_op;

   logic        r_req0_ready, r_req1_ready, r_rsp_valid, r_rsp_id, r_busy;
   logic [31:0] r_rsp_result;
   logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_busy;
   logic [31:0] f_rsp_result;
`ifdef ALU_ARB_OVF_EN
   logic        r_rsp_ovf, f_rsp_ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.PRIO_FIXED(0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(r_req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(r_req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(r_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(r_rsp_id), .rsp_result(r_rsp_result),
`ifdef ALU_ARB_OVF_EN
      .rsp_ovf(r_rsp_ovf),
`endif
      .busy(r_busy)
   );

   alu_arbiter #(.PRIO_FIXED(1)) dut_fix (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(f_req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(f_req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
`ifdef ALU_ARB_OVF_EN
      .rsp_ovf(f_rsp_ovf),
`endif
      .busy(f_busy)
   );

   // Reference ALU in 64-bit integer arithmetic, truncated to 32 bits.
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      longint unsigned x;
      case (op)
         2'd0:    x = longint'(a) + longint'(b);
         2'd1:    x = longint'(a) - longint'(b);
         2'd2:    x = longint'(a & b);
         default: x = longint'(a | b);
      endcase
      return x[31:0];
   endfunction

   // Overflow = exact signed result falls outside the 32-bit signed range.
   function automatic bit ref_ovf(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      s  = (op == 2'd0) ? sa + sb : sa - sb;
      return (op[1] == 1'b0) && ((s > 64'sh7FFFFFFF) || (s < -64'sh80000000));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload();
      req0_a  = $urandom;
      req0_b  = $urandom;
      req0_op = 2'($urandom_range(0, 3));
      req1_a  = $urandom;
      req1_b  = $urandom;
      req1_op = 2'($urandom_range(0, 3));
   endtask

   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rand_payload();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({r_rsp_valid, r_rsp_id, r_busy, f_rsp_valid, f_busy} !== 5'b0 ||
          r_rsp_result !== 32'h0 || f_rsp_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got vld=%b id=%b busy=%b res=%h want all 0",
                  r_rsp_valid, r_rsp_id, r_busy, r_rsp_result);
      end
`ifdef ALU_ARB_OVF_EN
      checks++;
      if (r_rsp_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf got %b want 0", r_rsp_ovf);
      end
`endif
      #1 reset = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle got %b want 0000",
                  {r_req0_ready, r_req1_ready, r_rsp_valid, r_busy});
      end
      tick();
   endtask

   task automatic test_basic_add();
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 2'b00;
      @(negedge clk);
      checks++;
      if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_busy} !== 4'b1000) begin
         errors++;
         $display("FAIL basic_accept got %b want 1000",
                  {r_req0_ready, r_req1_ready, r_rsp_valid, r_busy});
      end
      tick();
      req0_valid = 1'b0; req0_a = $urandom;
      @(negedge clk);
      checks++;
      if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_busy} !== 4'b0001) begin
         errors++;
         $display("FAIL basic_exec got %b want 0001",
                  {r_req0_ready, r_req1_ready, r_rsp_valid, r_busy});
      end
      tick();
      @(negedge clk);
      checks++;
      if (r_rsp_valid !== 1'b1 || r_rsp_result !== 32'd12 || r_rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL basic_resp got vld=%b res=%0d id=%b want vld=1 res=12 id=0",
                  r_rsp_valid, r_rsp_result, r_rsp_id);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({r_rsp_valid, r_busy} !== 2'b00) begin
         errors++;
         $display("FAIL basic_done got vld=%b busy=%b want 0 0", r_rsp_valid, r_busy);
      end
   endtask

   task automatic test_both_valid();
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd10;     req0_b = 32'd3;      req0_op = 2'b01;
      req1_valid = 1'b1; req1_a = 32'hF0F0;   req1_b = 32'hFF00;   req1_op = 2'b10;
      @(negedge clk);
      checks++;
      if ({r_req0_ready, r_req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL both_grant0 got %b want 10", {r_req0_ready, r_req1_ready});
      end
      tick();
      req0_valid = 1'b0; req0_a = $urandom;
      tick();
      @(negedge clk);
      checks++;
      if (r_rsp_valid !== 1'b1 || r_rsp_result !== 32'd7 || r_rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL both_rsp0 got vld=%b res=%h id=%b want 1 00000007 0",
                  r_rsp_valid, r_rsp_result, r_rsp_id);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({r_req0_ready, r_req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL both_grant1 got %b want 01", {r_req0_ready, r_req1_ready});
      end
      tick();
      req1_valid = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (r_rsp_valid !== 1'b1 || r_rsp_result !== 32'h0000F000 || r_rsp_id !== 1'b1) begin
         errors++;
         $display("FAIL both_rsp1 got vld=%b res=%h id=%b want 1 0000f000 1",
                  r_rsp_valid, r_rsp_result, r_rsp_id);
      end
      tick();
   endtask

   task automatic test_stall();
      logic [31:0] exp;
      do_reset();
      req0_valid = 1'b1; req0_op = 2'b11;
      exp = ref_alu(req0_a, req0_b, req0_op);
      tick();
      req1_valid = 1'b1;
      rand_payload();
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_busy} !== 4'b0011 ||
             r_rsp_result !== exp || r_rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d] got flags=%b res=%h id=%b want 0011 %h 0", i,
                     {r_req0_ready, r_req1_ready, r_rsp_valid, r_busy}, r_rsp_result,
                     r_rsp_id, exp);
         end
         tick();
         rand_payload();
      end
      rsp_ready = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if ({r_req0_ready, r_req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL stall_rr_next got %b want 01", {r_req0_ready, r_req1_ready});
      end
      tick();
   endtask

   task automatic test_overflow();
      logic [31:0] va [2];
      logic [31:0] vr [2];
      bit          vo [2];
      va[0] = 32'hFFFFFFFF; vr[0] = 32'h00000000; vo[0] = 1'b0;
      va[1] = 32'h7FFFFFFF; vr[1] = 32'h80000000; vo[1] = 1'b1;
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req0_valid = 1'b1; req0_a = va[i]; req0_b = 32'd1; req0_op = 2'b00;
         tick();
         req0_valid = 1'b0;
         tick();
         @(negedge clk);
         checks++;
         if (r_rsp_valid !== 1'b1 || r_rsp_result !== vr[i]) begin
            errors++;
            $display("FAIL ovf_result[%0d] got vld=%b res=%h want 1 %h", i, r_rsp_valid,
                     r_rsp_result, vr[i]);
         end
`ifdef ALU_ARB_OVF_EN
         checks++;
         if (r_rsp_ovf !== vo[i]) begin
            errors++;
            $display("FAIL ovf_flag[%0d] got %b want %b", i, r_rsp_ovf, vo[i]);
         end
`endif
         tick();
      end
   endtask

   task automatic test_abort();
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (r_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_exec got busy=%b want 1", r_busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({r_rsp_valid, r_busy} !== 2'b00) begin
         errors++;
         $display("FAIL abort_immediate got vld=%b busy=%b want 0 0", r_rsp_valid, r_busy);
      end
      #1 reset = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({r_rsp_valid, r_busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_rsp[%0d] got vld=%b busy=%b want 0 0", i,
                     r_rsp_valid, r_busy);
         end
         tick();
      end
   endtask

   task automatic test_prio_fixed();
      logic [31:0] q[$];
      int          n_rsp = 0;
      int          n_r1  = 0;
      do_reset();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (f_req1_ready === 1'b1) n_r1++;
         if (f_req0_ready === 1'b1) q.push_back(ref_alu(req0_a, req0_b, req0_op));
         if (f_rsp_valid === 1'b1) begin
            n_rsp++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL prio_rsp[%0d] got unexpected response res=%h want none",
                        n_rsp, f_rsp_result);
            end else if (f_rsp_id !== 1'b0 || f_rsp_result !== q[0]) begin
               errors++;
               $display("FAIL prio_rsp[%0d] got id=%b res=%h want id=0 res=%h", n_rsp,
                        f_rsp_id, f_rsp_result, q[0]);
            end
            if (q.size() != 0) void'(q.pop_front());
         end
         tick();
         rand_payload();
      end
      checks++;
      if (n_rsp != 10 || n_r1 != 0) begin
         errors++;
         $display("FAIL prio_totals got rsp=%0d req1_ready=%0d want rsp=10 req1_ready=0",
                  n_rsp, n_r1);
      end
   endtask

   // Transaction model: age counts edges since accept (-1 = no operation in flight).
   task automatic test_random();
      int          age  = -1;
      bit          m_rr = 1'b0;
      bit          m_id;
      logic [31:0] m_res;
      bit          m_ovf;
      bit          acc;
      logic [3:0]  exp_flags;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         rsp_ready  = ($urandom_range(0, 2) != 0);
         rand_payload();
         @(negedge clk);
         acc = 1'b0;
         exp_flags = {2'b00, (age >= 2), (age >= 0)};
         if (age < 0 && (req0_valid || req1_valid)) begin
            acc  = 1'b1;
            m_id = (req0_valid && req1_valid) ? m_rr : req1_valid;
            exp_flags[3:2] = m_id ? 2'b01 : 2'b10;
            m_res = m_id ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
            m_ovf = m_id ? ref_ovf(req1_a, req1_b, req1_op) : ref_ovf(req0_a, req0_b, req0_op);
         end
         checks++;
         if ({r_req0_ready, r_req1_ready, r_rsp_valid, r_busy} !== exp_flags) begin
            errors++;
            $display("FAIL rand_flags[%0d] got %b want %b", c,
                     {r_req0_ready, r_req1_ready, r_rsp_valid, r_busy}, exp_flags);
         end
         if (age >= 2) begin
            checks++;
            if (r_rsp_result !== m_res || r_rsp_id !== m_id) begin
               errors++;
               $display("FAIL rand_rsp[%0d] got res=%h id=%b want res=%h id=%b", c,
                        r_rsp_result, r_rsp_id, m_res, m_id);
            end
`ifdef ALU_ARB_OVF_EN
            checks++;
            if (r_rsp_ovf !== m_ovf) begin
               errors++;
               $display("FAIL rand_ovf[%0d] got %b want %b", c, r_rsp_ovf, m_ovf);
            end
`endif
         end
         if (acc) age = 1;
         else if (age >= 2 && rsp_ready) begin
            age  = -1;
            m_rr = !m_rr;
         end else if (age >= 1) age++;
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      rand_payload();
      test_reset();
      test_basic_add();
      test_both_valid();
      test_stall();
      test_overflow();
      test_abort();
      test_prio_fixed();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
